// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler for the SDRAM video path.
// Rotates camera frames across NUM_BUFS SDRAM buffers so the writer never
// lands on the buffer being displayed or on the newest complete frame, and
// sequences the write/read engines through their request handshakes.
//
// Handshake (both engines, four-phase): *_req rises once a buffer index has
// been chosen and stays high, with *_addr_index stable, until *_req_ack is
// sampled high; *_req then drops and the scheduler waits for *_req_ack to be
// sampled low before treating the engine as busy. A 1-cycle *_finish pulse
// while busy marks the frame as fully transferred.
module frame_buf_sched #(
    parameter int NUM_BUFS = 3,
    parameter int CNT_BITS = 8
) (
    input  logic                mem_clk,
    input  logic                rst,
    input  logic                Sdr_init_done,
    input  logic                cam_frame_start,
    input  logic                disp_frame_start,
    output logic                write_req,
    output logic [1:0]          write_addr_index,
    input  logic                write_req_ack,
    input  logic                write_finish,
    output logic                read_req,
    output logic [1:0]          read_addr_index,
    input  logic                read_req_ack,
    input  logic                read_finish,
    output logic                frame_valid,
    output logic [CNT_BITS-1:0] wr_drop_cnt,
    output logic [CNT_BITS-1:0] rd_repeat_cnt,
    output logic [2:0]          wr_state_dbg,
    output logic [2:0]          rd_state_dbg,
    output logic [1:0]          done_idx_dbg
);

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_SEL   = 3'd1,
        W_REQ   = 3'd2,
        W_ACKED = 3'd3,
        W_BUSY  = 3'd4
    } wr_state_t;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_SEL   = 3'd1,
        R_REQ   = 3'd2,
        R_ACKED = 3'd3,
        R_BUSY  = 3'd4
    } rd_state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [1:0] wr_idx, wr_idx_nxt;
    logic [1:0] rd_idx, rd_idx_nxt;
    logic [1:0] done_idx, done_idx_nxt;
    logic       done_valid, done_valid_nxt;
    logic       wr_drop_inc;
    logic       rd_repeat_inc;

    logic [1:0] wr_pick;
    logic [2:0] wr_sum;
    logic       wr_found;

    // Candidate write buffer: first index after wr_idx (mod NUM_BUFS) that is
    // neither displayed nor the newest complete frame.
    always_comb begin
        wr_pick  = wr_idx;
        wr_found = 1'b0;
        wr_sum   = 3'd0;
        for (int k = 1; k <= NUM_BUFS; k++) begin
            wr_sum = {1'b0, wr_idx} + 3'(k);
            if (wr_sum >= 3'(NUM_BUFS)) begin
                wr_sum = wr_sum - 3'(NUM_BUFS);
            end
            if (!wr_found && (wr_sum[1:0] != rd_idx) &&
                !(done_valid && (wr_sum[1:0] == done_idx))) begin
                wr_pick  = wr_sum[1:0];
                wr_found = 1'b1;
            end
        end
    end

    // Write FSM next state, buffer bookkeeping and drop events.
    always_comb begin
        wr_state_nxt   = wr_state;
        wr_idx_nxt     = wr_idx;
        done_idx_nxt   = done_idx;
        done_valid_nxt = done_valid;
        wr_drop_inc    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (cam_frame_start && Sdr_init_done) begin
                    wr_state_nxt = W_SEL;
                end
            end
            W_SEL: begin
                wr_idx_nxt   = wr_pick;
                wr_state_nxt = W_REQ;
                wr_drop_inc  = cam_frame_start;
            end
            W_REQ: begin
                if (write_req_ack) begin
                    wr_state_nxt = W_ACKED;
                end
                wr_drop_inc = cam_frame_start;
            end
            W_ACKED: begin
                if (!write_req_ack) begin
                    wr_state_nxt = W_BUSY;
                end
                wr_drop_inc = cam_frame_start;
            end
            W_BUSY: begin
                if (write_finish) begin
                    // Completion wins; a coincident frame start then selects
                    // against the freshly completed buffer.
                    done_idx_nxt   = wr_idx;
                    done_valid_nxt = 1'b1;
                    wr_state_nxt   = cam_frame_start ? W_SEL : W_IDLE;
                end else if (cam_frame_start) begin
                    // Abort: the partial buffer never becomes done.
                    wr_drop_inc  = 1'b1;
                    wr_state_nxt = W_SEL;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state; done_*_nxt carries a same-cycle write completion.
    always_comb begin
        rd_state_nxt  = rd_state;
        rd_idx_nxt    = rd_idx;
        rd_repeat_inc = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (disp_frame_start && Sdr_init_done) begin
                    rd_state_nxt = R_SEL;
                end
            end
            R_SEL: begin
                if (done_valid_nxt) begin
                    rd_repeat_inc = (done_idx_nxt == rd_idx);
                    rd_idx_nxt    = done_idx_nxt;
                    rd_state_nxt  = R_REQ;
                end else begin
                    rd_repeat_inc = 1'b1;
                    rd_state_nxt  = R_IDLE;
                end
            end
            R_REQ: begin
                if (read_req_ack) begin
                    rd_state_nxt = R_ACKED;
                end
            end
            R_ACKED: begin
                if (!read_req_ack) begin
                    rd_state_nxt = R_BUSY;
                end
            end
            R_BUSY: begin
                if (read_finish) begin
                    rd_state_nxt = disp_frame_start ? R_SEL : R_IDLE;
                end else if (disp_frame_start) begin
                    rd_state_nxt = R_SEL;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // State, index and saturating counter registers.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            wr_state      <= W_IDLE;
            rd_state      <= R_IDLE;
            wr_idx        <= 2'd0;
            rd_idx        <= 2'd0;
            done_idx      <= 2'd0;
            done_valid    <= 1'b0;
            wr_drop_cnt   <= '0;
            rd_repeat_cnt <= '0;
        end else begin
            wr_state   <= wr_state_nxt;
            rd_state   <= rd_state_nxt;
            wr_idx     <= wr_idx_nxt;
            rd_idx     <= rd_idx_nxt;
            done_idx   <= done_idx_nxt;
            done_valid <= done_valid_nxt;
            if (wr_drop_inc && (wr_drop_cnt != '1)) begin
                wr_drop_cnt <= wr_drop_cnt + CNT_ONE;
            end
            if (rd_repeat_inc && (rd_repeat_cnt != '1)) begin
                rd_repeat_cnt <= rd_repeat_cnt + CNT_ONE;
            end
        end
    end

    assign write_req        = (wr_state == W_REQ);
    assign read_req         = (rd_state == R_REQ);
    assign write_addr_index = wr_idx;
    assign read_addr_index  = rd_idx;
    assign frame_valid      = done_valid;
    assign wr_state_dbg     = wr_state;
    assign rd_state_dbg     = rd_state;
    assign done_idx_dbg     = done_idx;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Testbench for frame_buf_sched: frame-level vector table plus hand-written
// corner sequences; requested buffer indices are checked by a scoreboard.
module tb_frame_buf_sched;

    localparam int CNT_BITS = 8;
    localparam int S_IDLE  = 0;
    localparam int S_SEL   = 1;
    localparam int S_REQ   = 2;
    localparam int S_ACKED = 3;
    localparam int S_BUSY  = 4;
    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;

    logic                mem_clk;
    logic                rst;
    logic                Sdr_init_done;
    logic                cam_frame_start;
    logic                disp_frame_start;
    logic                write_req;
    logic [1:0]          write_addr_index;
    logic                write_req_ack;
    logic                write_finish;
    logic                read_req;
    logic [1:0]          read_addr_index;
    logic                read_req_ack;
    logic                read_finish;
    logic                frame_valid;
    logic [CNT_BITS-1:0] wr_drop_cnt;
    logic [CNT_BITS-1:0] rd_repeat_cnt;
    logic [2:0]          wr_state_dbg;
    logic [2:0]          rd_state_dbg;
    logic [1:0]          done_idx_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_wr_q[$];
    logic [1:0] exp_rd_q[$];

    typedef struct {
        int         op;
        int         idx;
        logic       fv;
        logic [1:0] done;
        int         drop;
        int         rep;
    } vec_t;

    vec_t vt[11];

    frame_buf_sched #(.NUM_BUFS(3), .CNT_BITS(CNT_BITS)) dut (
        .mem_clk          (mem_clk),
        .rst              (rst),
        .Sdr_init_done    (Sdr_init_done),
        .cam_frame_start  (cam_frame_start),
        .disp_frame_start (disp_frame_start),
        .write_req        (write_req),
        .write_addr_index (write_addr_index),
        .write_req_ack    (write_req_ack),
        .write_finish     (write_finish),
        .read_req         (read_req),
        .read_addr_index  (read_addr_index),
        .read_req_ack     (read_req_ack),
        .read_finish      (read_finish),
        .frame_valid      (frame_valid),
        .wr_drop_cnt      (wr_drop_cnt),
        .rd_repeat_cnt    (rd_repeat_cnt),
        .wr_state_dbg     (wr_state_dbg),
        .rd_state_dbg     (rd_state_dbg),
        .done_idx_dbg     (done_idx_dbg)
    );

    // clock / reset
    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic cam_pulse();
        cam_frame_start = 1'b1;
        cyc(1);
        cam_frame_start = 1'b0;
    endtask

    task automatic disp_pulse();
        disp_frame_start = 1'b1;
        cyc(1);
        disp_frame_start = 1'b0;
    endtask

    task automatic wr_finish_pulse();
        write_finish = 1'b1;
        cyc(1);
        write_finish = 1'b0;
    endtask

    task automatic rd_finish_pulse();
        read_finish = 1'b1;
        cyc(1);
        read_finish = 1'b0;
    endtask

    task automatic wr_handshake(input int dly);
        int t;
        t = 0;
        while (write_req !== 1'b1 && t < 50) begin
            cyc(1);
            t++;
        end
        check("wr_req_seen", write_req, 1);
        if (write_req === 1'b1) begin
            cyc(dly);
            write_req_ack = 1'b1;
            cyc(1);
            check("wr_req_drop_after_ack", write_req, 0);
            write_req_ack = 1'b0;
            cyc(1);
            check("wr_busy_state", wr_state_dbg, S_BUSY);
        end
    endtask

    task automatic rd_handshake(input int dly);
        int t;
        t = 0;
        while (read_req !== 1'b1 && t < 50) begin
            cyc(1);
            t++;
        end
        check("rd_req_seen", read_req, 1);
        if (read_req === 1'b1) begin
            cyc(dly);
            read_req_ack = 1'b1;
            cyc(1);
            check("rd_req_drop_after_ack", read_req, 0);
            read_req_ack = 1'b0;
            cyc(1);
            check("rd_busy_state", rd_state_dbg, S_BUSY);
        end
    endtask

    // scoreboard: compare the index on every rising request
    logic wr_req_q = 1'b0;
    logic rd_req_q = 1'b0;
    always @(negedge mem_clk) begin
        logic [1:0] e;
        if (write_req && !wr_req_q) begin
            if (exp_wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_sb_unexpected: write_req rose with index %0d, none expected", write_addr_index);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_sb_index", write_addr_index, e);
            end
        end
        if (read_req && !rd_req_q) begin
            if (exp_rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_sb_unexpected: read_req rose with index %0d, none expected", read_addr_index);
            end else begin
                e = exp_rd_q.pop_front();
                check("rd_sb_index", read_addr_index, e);
            end
        end
        wr_req_q = write_req;
        rd_req_q = read_req;
    end

    initial begin
        logic [1:0] cur;

        // idx -1: display start with no complete frame, no read expected
        vt[0]  = '{OP_RD, -1, 1'b0, 2'd0, 0, 1};
        vt[1]  = '{OP_WR,  1, 1'b1, 2'd1, 0, 1};
        vt[2]  = '{OP_RD,  1, 1'b1, 2'd1, 0, 1};
        vt[3]  = '{OP_WR,  2, 1'b1, 2'd2, 0, 1};
        vt[4]  = '{OP_WR,  0, 1'b1, 2'd0, 0, 1};   // rd=1, done=2
        vt[5]  = '{OP_WR,  2, 1'b1, 2'd2, 0, 1};   // rd=1, done=0
        vt[6]  = '{OP_RD,  2, 1'b1, 2'd2, 0, 1};
        vt[7]  = '{OP_WR,  0, 1'b1, 2'd0, 0, 1};
        vt[8]  = '{OP_WR,  1, 1'b1, 2'd1, 0, 1};   // rd=2, done=0
        vt[9]  = '{OP_RD,  1, 1'b1, 2'd1, 0, 1};
        vt[10] = '{OP_RD,  1, 1'b1, 2'd1, 0, 2};   // same buffer again

        rst              = 1'b1;
        Sdr_init_done    = 1'b0;
        cam_frame_start  = 1'b0;
        disp_frame_start = 1'b0;
        write_req_ack    = 1'b0;
        write_finish     = 1'b0;
        read_req_ack     = 1'b0;
        read_finish      = 1'b0;
        cyc(2);

        check("rst_write_req", write_req, 0);
        check("rst_read_req", read_req, 0);
        check("rst_wr_index", write_addr_index, 0);
        check("rst_rd_index", read_addr_index, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_drop_cnt", wr_drop_cnt, 0);
        check("rst_repeat_cnt", rd_repeat_cnt, 0);
        check("rst_wr_state", wr_state_dbg, S_IDLE);
        check("rst_rd_state", rd_state_dbg, S_IDLE);

        rst = 1'b0;
        cyc(1);

        // SDRAM not ready: frame starts are ignored
        cam_frame_start  = 1'b1;
        disp_frame_start = 1'b1;
        cyc(1);
        cam_frame_start  = 1'b0;
        disp_frame_start = 1'b0;
        cyc(3);
        check("noinit_wr_state", wr_state_dbg, S_IDLE);
        check("noinit_rd_state", rd_state_dbg, S_IDLE);
        check("noinit_repeat_cnt", rd_repeat_cnt, 0);
        Sdr_init_done = 1'b1;
        cyc(1);

        // table-driven frame sequence
        for (int i = 0; i < 11; i++) begin
            if (vt[i].op == OP_WR) begin
                exp_wr_q.push_back(2'(vt[i].idx));
                cam_pulse();
                wr_handshake(3);
                wr_finish_pulse();
            end else if (vt[i].idx < 0) begin
                disp_pulse();
                cyc(3);
                check($sformatf("tbl%0d_no_read_req", i), read_req, 0);
                check($sformatf("tbl%0d_rd_idle", i), rd_state_dbg, S_IDLE);
            end else begin
                exp_rd_q.push_back(2'(vt[i].idx));
                disp_pulse();
                rd_handshake(3);
                rd_finish_pulse();
            end
            check($sformatf("tbl%0d_frame_valid", i), frame_valid, vt[i].fv);
            check($sformatf("tbl%0d_done_idx", i), done_idx_dbg, vt[i].done);
            check($sformatf("tbl%0d_drop_cnt", i), wr_drop_cnt, vt[i].drop);
            check($sformatf("tbl%0d_repeat_cnt", i), rd_repeat_cnt, vt[i].rep);
        end

        // A: frame start to request latency (wr=1, rd=1, done=1 -> picks 2)
        exp_wr_q.push_back(2'd2);
        cam_pulse();
        check("a_sel_state", wr_state_dbg, S_SEL);
        check("a_req_low_n1", write_req, 0);
        cyc(1);
        check("a_req_high_n2", write_req, 1);
        wr_handshake(3);
        wr_finish_pulse();
        check("a_done_idx", done_idx_dbg, 2);

        // B: abort in W_BUSY, then a start during W_REQ (rd=1, done=2)
        exp_wr_q.push_back(2'd0);
        cam_pulse();
        wr_handshake(3);
        exp_wr_q.push_back(2'd0);
        cam_pulse();
        check("b_abort_drop_cnt", wr_drop_cnt, 1);
        check("b_abort_state", wr_state_dbg, S_SEL);
        check("b_abort_frame_valid", frame_valid, 1);
        check("b_abort_done_idx", done_idx_dbg, 2);
        cyc(1);
        check("b_in_req", wr_state_dbg, S_REQ);
        cam_pulse();
        check("b_req_drop_cnt", wr_drop_cnt, 2);
        check("b_req_state_kept", wr_state_dbg, S_REQ);
        wr_handshake(2);
        wr_finish_pulse();
        check("b_done_idx", done_idx_dbg, 0);

        // C1: write_finish and disp_frame_start together (rd=1, done=0)
        exp_wr_q.push_back(2'd2);
        cam_pulse();
        wr_handshake(3);
        exp_rd_q.push_back(2'd2);
        write_finish     = 1'b1;
        disp_frame_start = 1'b1;
        cyc(1);
        write_finish     = 1'b0;
        disp_frame_start = 1'b0;
        rd_handshake(3);
        rd_finish_pulse();
        check("c1_repeat_cnt", rd_repeat_cnt, 2);
        check("c1_done_idx", done_idx_dbg, 2);

        // C2: write_finish lands in the R_SEL cycle (rd=2, done=2)
        exp_wr_q.push_back(2'd0);
        cam_pulse();
        wr_handshake(3);
        exp_rd_q.push_back(2'd0);
        disp_pulse();
        check("c2_rd_sel", rd_state_dbg, S_SEL);
        wr_finish_pulse();
        rd_handshake(3);
        rd_finish_pulse();
        check("c2_repeat_cnt", rd_repeat_cnt, 2);
        check("c2_done_idx", done_idx_dbg, 0);

        // D: 300 aborted frames saturate the drop counter (rd=0, done=0)
        cur = 2'd1;
        exp_wr_q.push_back(cur);
        cam_pulse();
        for (int i = 0; i < 300; i++) begin
            wr_handshake(1);
            cur = (cur == 2'd1) ? 2'd2 : 2'd1;
            exp_wr_q.push_back(cur);
            cam_pulse();
        end
        check("d_drop_saturated", wr_drop_cnt, 255);
        check("d_done_unchanged", done_idx_dbg, 0);
        cyc(1);
        check("d_req_high", write_req, 1);

        // reset in the middle of W_REQ
        @(negedge mem_clk);
        #1;
        rst = 1'b1;
        #1;
        check("d_rst_write_req", write_req, 0);
        check("d_rst_wr_state", wr_state_dbg, S_IDLE);
        check("d_rst_drop_cnt", wr_drop_cnt, 0);
        check("d_rst_repeat_cnt", rd_repeat_cnt, 0);
        check("d_rst_frame_valid", frame_valid, 0);
        check("d_rst_wr_index", write_addr_index, 0);
        check("d_rst_rd_index", read_addr_index, 0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        check("d_post_rst_write_req", write_req, 0);
        check("d_post_rst_wr_state", wr_state_dbg, S_IDLE);

        check("sb_wr_queue_empty", exp_wr_q.size(), 0);
        check("sb_rd_queue_empty", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
